// File: rtl/alu_exec_if.sv
// Handshake bundle between the decoder, the ALU execute stage and its consumer.
// Upstream side: in_valid/in_ready with op/a/b. Downstream side: out_valid/out_ready
// with result, flags and the completed-operation counter.
interface alu_exec_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             flag_z;
  logic             flag_n;
  logic             flag_c;
  logic             flag_v;
  logic             flag_ill;
  logic [CNT_W-1:0] op_count;

  // Driven by the environment: supplies operations, consumes results.
  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, result, flag_z, flag_n, flag_c, flag_v, flag_ill, op_count
  );

  // The execute stage itself.
  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, result, flag_z, flag_n, flag_c, flag_v, flag_ill, op_count
  );
endinterface

// File: rtl/alu_exec_stage.sv
// ALU execute stage: computes ADD/SUB/XOR/OR/AND with Z/N/C/V/ILL flags, presents
// them through a registered valid/ready output backed by a one-entry skid buffer,
// and counts output handshakes.
module alu_exec_stage #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic     clk,
  input  logic     rst,
  alu_exec_if.slave bus
);

  typedef enum logic [3:0] {
    OP_ADD = 4'b0000,
    OP_SUB = 4'b0001,
    OP_XOR = 4'b0010,
    OP_OR  = 4'b0011,
    OP_AND = 4'b0100
  } op_e;

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             z;
    logic             n;
    logic             c;
    logic             v;
    logic             ill;
  } out_t;

  out_t             calc;
  out_t             out_q, out_d;
  out_t             skid_q, skid_d;
  logic             out_valid_q, out_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic             in_ready_q, in_ready_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   sum_w;
  logic             accept;
  logic             out_hs;

  assign accept = bus.in_valid & in_ready_q;
  assign out_hs = out_valid_q & bus.out_ready;

  // ALU datapath and flag generation from the current input operands.
  always_comb begin
    calc  = '0;
    sum_w = '0;
    case (bus.op)
      OP_ADD: begin
        sum_w    = {1'b0, bus.a} + {1'b0, bus.b};
        calc.res = sum_w[WIDTH-1:0];
        calc.c   = sum_w[WIDTH];
        calc.v   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) & (sum_w[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_SUB: begin
        sum_w    = {1'b0, bus.a} + {1'b0, ~bus.b} + {{WIDTH{1'b0}}, 1'b1};
        calc.res = sum_w[WIDTH-1:0];
        calc.c   = sum_w[WIDTH];
        calc.v   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) & (sum_w[WIDTH-1] != bus.a[WIDTH-1]);
      end
      OP_XOR:  calc.res = bus.a ^ bus.b;
      OP_OR:   calc.res = bus.a | bus.b;
      OP_AND:  calc.res = bus.a & bus.b;
      default: calc.ill = 1'b1;
    endcase
    calc.z = (calc.res == '0);
    calc.n = calc.res[WIDTH-1];
  end

  // Next-state selection for output register, skid entry, ready and counter.
  // in_ready_q always equals !skid_valid_q, so a new accept never coincides with
  // draining the skid; that keeps the first branch free of a third data path.
  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (out_hs && skid_valid_q) begin
      out_d        = skid_q;
      skid_valid_d = 1'b0;
      out_valid_d  = 1'b1;
    end else if (out_hs && accept) begin
      out_d       = calc;
      out_valid_d = 1'b1;
    end else if (out_hs) begin
      out_valid_d = 1'b0;
    end else if (accept && !out_valid_q) begin
      out_d       = calc;
      out_valid_d = 1'b1;
    end else if (accept) begin
      skid_d       = calc;
      skid_valid_d = 1'b1;
    end
    in_ready_d = !skid_valid_d;
    cnt_d      = cnt_q + {{(CNT_W-1){1'b0}}, out_hs};
  end

  // State registers with synchronous reset flushing output and skid.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
      cnt_q        <= '0;
    end else begin
      out_q        <= out_d;
      skid_q       <= skid_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
      cnt_q        <= cnt_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = out_q.res;
  assign bus.flag_z    = out_q.z;
  assign bus.flag_n    = out_q.n;
  assign bus.flag_c    = out_q.c;
  assign bus.flag_v    = out_q.v;
  assign bus.flag_ill  = out_q.ill;
  assign bus.op_count  = cnt_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed bench for alu_exec_stage at WIDTH=8, CNT_W=4.
module tb_alu_exec_stage;

  logic clk;
  logic rst;
  int unsigned npass;
  int unsigned ntot;
  int unsigned exp_cnt;

  alu_exec_if #(.WIDTH(8), .CNT_W(4)) bus ();

  alu_exec_stage #(.WIDTH(8), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [4:0] flags();
    return {bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v, bus.flag_ill};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One op with out_ready held high: result appears the cycle after accept and
  // is consumed at the following edge. Flags are {z,n,c,v,ill}.
  task automatic send(input string tag, input logic [3:0] op, input logic [7:0] a,
                      input logic [7:0] b, input logic [7:0] er, input logic [4:0] ef);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.op        = op;
    bus.a         = a;
    bus.b         = b;
    tick();
    bus.in_valid = 1'b0;
    chk({tag, ".valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, ".result"}, 32'(bus.result), 32'(er));
    chk({tag, ".flags"}, 32'(flags()), 32'(ef));
    tick();
    exp_cnt = (exp_cnt + 1) % 16;
    chk({tag, ".drain"}, 32'(bus.out_valid), 32'd0);
    chk({tag, ".count"}, 32'(bus.op_count), exp_cnt);
  endtask

  initial begin
    npass = 0;
    ntot = 0;
    exp_cnt = 0;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.op = '0;
    bus.a = '0;
    bus.b = '0;
    tick();
    tick();
    chk("rst.out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst.in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst.count", 32'(bus.op_count), 32'd0);
    chk("rst.result", 32'(bus.result), 32'd0);
    chk("rst.flags", 32'(flags()), 32'd0);
    rst = 1'b0;
    tick();

    send("add_ovf",  4'h0, 8'h7F, 8'h01, 8'h80, 5'b01010);
    send("add_carry",4'h0, 8'hFF, 8'h01, 8'h00, 5'b10100);
    send("sub_eq",   4'h1, 8'h05, 8'h05, 8'h00, 5'b10100);
    send("sub_borrow",4'h1,8'h00, 8'h01, 8'hFF, 5'b01000);
    send("sub_ovf",  4'h1, 8'h80, 8'h01, 8'h7F, 5'b00110);
    send("xor",      4'h2, 8'hF0, 8'hFF, 8'h0F, 5'b00000);
    send("or",       4'h3, 8'hA0, 8'h05, 8'hA5, 5'b01000);
    send("and",      4'h4, 8'hA5, 8'h0F, 8'h05, 5'b00000);
    send("ill8",     4'h8, 8'h12, 8'h34, 8'h00, 5'b10001);
    send("ill5",     4'h5, 8'h03, 8'h04, 8'h00, 5'b10001);

    // Backpressure: X=ADD 1+1, Y=SUB 9-3, Z=XOR 0F^F0.
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.op = 4'h0; bus.a = 8'h01; bus.b = 8'h01;
    tick();
    chk("bp.x_valid", 32'(bus.out_valid), 32'd1);
    chk("bp.x_ready", 32'(bus.in_ready), 32'd1);
    bus.op = 4'h1; bus.a = 8'h09; bus.b = 8'h03;
    tick();
    chk("bp.y_ready", 32'(bus.in_ready), 32'd0);
    chk("bp.x_hold1", 32'(bus.result), 32'h02);
    bus.op = 4'h2; bus.a = 8'h0F; bus.b = 8'hF0;
    tick();
    chk("bp.z_held", 32'(bus.in_ready), 32'd0);
    chk("bp.x_hold2", 32'(bus.result), 32'h02);
    chk("bp.x_flags", 32'(flags()), 32'd0);
    bus.out_ready = 1'b1;
    tick();
    exp_cnt = (exp_cnt + 1) % 16;
    chk("bp.y_result", 32'(bus.result), 32'h06);
    chk("bp.y_valid", 32'(bus.out_valid), 32'd1);
    chk("bp.y_ready", 32'(bus.in_ready), 32'd1);
    chk("bp.y_count", 32'(bus.op_count), exp_cnt);
    tick();
    bus.in_valid = 1'b0;
    exp_cnt = (exp_cnt + 1) % 16;
    chk("bp.z_result", 32'(bus.result), 32'hFF);
    chk("bp.z_flags", 32'(flags()), 32'b01000);
    chk("bp.z_count", 32'(bus.op_count), exp_cnt);
    tick();
    exp_cnt = (exp_cnt + 1) % 16;
    chk("bp.empty", 32'(bus.out_valid), 32'd0);
    chk("bp.count3", 32'(bus.op_count), exp_cnt);

    // Reset while stalled with the skid full.
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1;
    bus.op = 4'h0; bus.a = 8'h10; bus.b = 8'h20;
    tick();
    bus.a = 8'h30;
    tick();
    bus.in_valid = 1'b0;
    chk("rs.full", 32'(bus.in_ready), 32'd0);
    chk("rs.valid", 32'(bus.out_valid), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_cnt = 0;
    chk("rs.out_valid", 32'(bus.out_valid), 32'd0);
    chk("rs.in_ready", 32'(bus.in_ready), 32'd1);
    chk("rs.count", 32'(bus.op_count), 32'd0);
    send("rs.add", 4'h0, 8'h01, 8'h02, 8'h03, 5'b00000);

    // Counter wrap: handshakes 2..17 since reset.
    for (int k = 2; k <= 17; k++) begin
      send("wrap", 4'h0, 8'(k), 8'(k), 8'(2 * k), 5'b00000);
      if (k == 16) chk("wrap.16", 32'(bus.op_count), 32'd0);
      if (k == 17) chk("wrap.17", 32'(bus.op_count), 32'd1);
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
